// File: rtl/alu4_sched.sv
// Round-robin scheduler sharing one external alu4 between two requesters.
// Optional feature macro: ALU4_SCHED_STATS_EN adds per-requester completion counters.
module alu4_sched #(
  parameter int INIT_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [5:0] req_op,
  output logic [1:0] req_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic [3:0] rsp_flags,
  input  logic       rsp_ready,
  output logic       busy
`ifdef ALU4_SCHED_STATS_EN
  ,
  output logic [7:0] stat_cnt0,
  output logic [7:0] stat_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic INIT_BIT = (INIT_PRIO != 0);

  state_t     state_reg, state_next;
  logic       prio_reg;
  logic       id_reg;
  logic [3:0] a_reg, b_reg;
  logic [2:0] op_reg;
  logic [3:0] result_reg, flags_reg;
  logic       grant;
  logic       any_req;

  logic [3:0] a_slice  [2];
  logic [3:0] b_slice  [2];
  logic [2:0] op_slice [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slice
    assign a_slice[gi]  = req_a[gi*4 +: 4];
    assign b_slice[gi]  = req_b[gi*4 +: 4];
    assign op_slice[gi] = req_op[gi*3 +: 3];
  end

  assign any_req = |req_valid;
  // Contention goes to the priority holder; otherwise the lone requester wins.
  assign grant   = (&req_valid) ? prio_reg : req_valid[1];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_reg == IDLE && any_req) req_ready[grant] = 1'b1;
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg   <= INIT_BIT;
      id_reg     <= 1'b0;
      a_reg      <= 4'd0;
      b_reg      <= 4'd0;
      op_reg     <= 3'd0;
      result_reg <= 4'd0;
      flags_reg  <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: if (any_req) begin
          id_reg <= grant;
          a_reg  <= a_slice[grant];
          b_reg  <= b_slice[grant];
          op_reg <= op_slice[grant];
        end
        EXEC: begin
          result_reg <= alu_result;
          flags_reg  <= alu_flags;
        end
        RESP: if (rsp_ready) prio_reg <= ~id_reg;
        default: ;
      endcase
    end
  end

  // ALU inputs come straight from registers so the shared ALU never sees request-side glitches.
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_op     = op_reg;
  assign rsp_id     = id_reg;
  assign rsp_result = result_reg;
  assign rsp_flags  = flags_reg;

`ifdef ALU4_SCHED_STATS_EN
  logic [7:0] cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge clk) begin
      if (reset)
        cnt_reg[gi] <= 8'd0;
      else if (state_reg == RESP && rsp_ready && id_reg == gi[0])
        cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
    end
  end

  assign stat_cnt0 = cnt_reg[0];
  assign stat_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_alu4_sched.sv
// Scoreboard bench for alu4_sched: an alu4 model closes the loop, an acceptor predicts grants,
// and a separate monitor pops expected responses. Build with ALU4_SCHED_STATS_EN to cover counters.
module tb_alu4_sched;

  localparam int INIT_PRIO = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic [5:0] req_op = 6'd0;
  logic [1:0] req_ready;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result, alu_flags;
  logic       rsp_valid, rsp_id;
  logic [3:0] rsp_result, rsp_flags;
  logic       rsp_ready = 1'b1;
  logic       busy;
`ifdef ALU4_SCHED_STATS_EN
  logic [7:0] stat_cnt0, stat_cnt1;
  int         cnt0 = 0, cnt1 = 0;
`endif

  alu4_sched #(.INIT_PRIO(INIT_PRIO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_ready(rsp_ready), .busy(busy)
`ifdef ALU4_SCHED_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural alu4: returns {result, c, n, z, v} using plain integer arithmetic.
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [3:0] r;
    logic c, v;
    int s, t;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: r = ~a;
      3'd1: r = ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: begin
        s = int'(a) + int'(b);
        r = 4'(s);
        c = (s > 15);
        t = int'($signed(a)) + int'($signed(b));
        v = (t > 7) || (t < -8);
      end
      default: begin
        s = int'(a) - int'(b);
        r = 4'(s);
        c = (a >= b);
        t = int'($signed(a)) - int'($signed(b));
        v = (t > 7) || (t < -8);
      end
    endcase
    return {r, c, r[3], (r == 4'd0), v};
  endfunction

  assign {alu_result, alu_flags} = alu_ref(alu_a, alu_b, alu_op);

  typedef struct {
    logic       id;
    logic [3:0] res;
    logic [3:0] flg;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  logic prio_m = INIT_PRIO[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // Acceptor: predicts the grant from the valid vector and the fairness state.
  logic       acc_inflight;
  logic       acc_g;
  logic [1:0] acc_exp;
  logic [7:0] acc_ref;
  always @(negedge clk) begin
    if (!reset) begin
      acc_inflight = (acc_cnt != done_cnt);
      chk("busy", busy, acc_inflight);
      if (acc_inflight) begin
        chk("req_ready_when_busy", req_ready, 2'b00);
      end else begin
        acc_exp = 2'b00;
        acc_g   = (req_valid == 2'b11) ? prio_m : req_valid[1];
        if (req_valid != 2'b00) acc_exp[acc_g] = 1'b1;
        chk("req_ready", req_ready, acc_exp);
        if (acc_exp != 2'b00) begin
          acc_ref = alu_ref(req_a[acc_g*4 +: 4], req_b[acc_g*4 +: 4], req_op[acc_g*3 +: 3]);
          sb.push_back('{id: acc_g, res: acc_ref[7:4], flg: acc_ref[3:0], cyc: cycle});
          $display("accept id=%0d a=%0h b=%0h op=%0d cycle=%0d", acc_g,
                   req_a[acc_g*4 +: 4], req_b[acc_g*4 +: 4], req_op[acc_g*3 +: 3], cycle);
          acc_cnt <= acc_cnt + 1;
        end
      end
    end
  end

  // Monitor: compares every cycle a response is presented, pops on handshake.
  logic prev_v = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      done_cnt <= acc_cnt;
      prio_m   <= INIT_PRIO[0];
      prev_v   = 1'b0;
`ifdef ALU4_SCHED_STATS_EN
      cnt0 = 0;
      cnt1 = 0;
`endif
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", rsp_valid, 1'b0);
        end else begin
          mon_e = sb[0];
          if (!prev_v) chk("latency", cycle, mon_e.cyc + 2);
          chk("rsp_id", rsp_id, mon_e.id);
          chk("rsp_result", rsp_result, mon_e.res);
          chk("rsp_flags", rsp_flags, mon_e.flg);
          if (rsp_ready) begin
            $display("response id=%0d result=%0h flags=%0b cycle=%0d", rsp_id, rsp_result, rsp_flags, cycle);
            void'(sb.pop_front());
            done_cnt <= done_cnt + 1;
            prio_m   <= ~mon_e.id;
`ifdef ALU4_SCHED_STATS_EN
            if (mon_e.id) cnt1++;
            else cnt0++;
`endif
          end
        end
      end else if (sb.size() != 0 && cycle > sb[0].cyc + 2) begin
        chk("rsp_late", rsp_valid, 1'b1);
      end
      prev_v = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_flags"}, rsp_flags, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    @(negedge clk);
    check_zero_outputs("reset");
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_op[i*3 +: 3] = op;
    req_valid[i]     = 1'b1;
  endtask

  task automatic send(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic got;
    got = 1'b0;
    set_req(i, a, b, op);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    chk("accept_timeout", got, 1'b1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      @(negedge clk);
      #1;
      if (!busy && sb.size() == 0) idle = 1'b1;
    end
    chk("idle_timeout", idle, 1'b1);
    tick();
  endtask

  initial begin
    logic [1:0] r;
    int k;

    do_reset();

    // Directed: lone requester 0 add, then requester 1 sub and overflowing add.
    rsp_ready = 1'b1;
    send(0, 4'd3, 4'd4, 3'd6);
    wait_idle();
    send(1, 4'd2, 4'd3, 3'd7);
    wait_idle();
    send(1, 4'd7, 4'd1, 3'd6);
    wait_idle();

    // Continuous contention from a fresh reset: grants must alternate.
    do_reset();
    set_req(0, 4'($urandom), 4'($urandom), 3'($urandom));
    set_req(1, 4'($urandom), 4'($urandom), 3'($urandom));
    k = 0;
    for (int c = 0; c < 100 && k < 6; c++) begin
      @(negedge clk);
      r = req_ready;
      if (r != 2'b00) begin
        chk("grant_order", r, (INIT_PRIO[0] ^ k[0]) ? 2'b10 : 2'b01);
        k++;
      end
      tick();
      if (r[0]) set_req(0, 4'($urandom), 4'($urandom), 3'($urandom));
      if (r[1]) set_req(1, 4'($urandom), 4'($urandom), 3'($urandom));
    end
    req_valid = 2'b00;
    chk("contention_count", k, 6);
    wait_idle();

    // Backpressure: hold RESP for 5 cycles while the other requester waits.
    rsp_ready = 1'b0;
    send(0, 4'd9, 4'd5, 3'd7);
    set_req(1, 4'd1, 4'd1, 3'd2);
    k = 0;
    for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_busy", busy, 1'b1);
    end
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset while in EXEC: transaction must vanish.
    set_req(0, 4'd5, 4'd6, 3'd3);
    for (int c = 0; c < 20 && !req_ready[0]; c++) @(negedge clk);
    tick();
    req_valid = 2'b00;
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_zero_outputs("mid_reset");
    tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // Randomized traffic with random backpressure and dropped requests.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && r[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(19) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
      end
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_idle();

`ifdef ALU4_SCHED_STATS_EN
    do_reset();
    for (int n = 0; n < 257; n++) begin
      send(0, 4'($urandom), 4'($urandom), 3'($urandom));
      wait_idle();
    end
    chk("stat_cnt0", stat_cnt0, 8'(cnt0));
    chk("stat_cnt1", stat_cnt1, 8'(cnt1));
`endif

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
